// File: rtl/urv_mem_arbiter_pkg.sv
// urv_mem_arbiter_pkg
// Shared types for the uRV memory arbiter: FSM state encoding, request
// kinds, grant-owner constants and the packed payload that the data port
// buffer holds.
package urv_mem_arbiter_pkg;

  // Arbiter FSM: IDLE grants an access, WAIT covers the RAM read latency.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Kind of access held in a request buffer.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } req_kind_e;

  // Which port owns (or last owned) the RAM bank.
  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } owner_e;

  // Everything the data port must remember between its request pulse and
  // its grant.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  lanes;
    req_kind_e   kind;
  } data_req_t;

  localparam int DATA_REQ_W = $bits(data_req_t);

endpackage

// File: rtl/urv_req_buffer.sv
// urv_req_buffer
// One-entry request capture register with a full flag. The owner only
// asserts load while the entry is empty and clear while it is full.
//   clk_i, rst_i : clock, synchronous active-low reset
//   load         : capture load_data and mark the entry full
//   load_data    : request payload
//   clear        : entry was granted, mark it empty
//   full         : entry holds a pending request
//   data         : pending request payload
module urv_req_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             clear,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/urv_mem_arbiter.sv
// urv_mem_arbiter
// Shares one single-port, byte-lane RAM bank between the uRV fetch port and
// the data load/store port with round-robin arbitration, and decodes one
// memory-mapped I/O word on the data port.
//   clk_i, rst_i          : clock, synchronous active-low reset
//   im_req_i/im_addr_i    : fetch request pulse and byte address
//   im_data_o/im_valid_o  : fetched word (held) and its completion pulse
//   dm_load_i/dm_store_i  : data request pulses (store wins if both)
//   dm_addr_i, dm_data_s_i, dm_data_select_i : data address, store data, lanes
//   dm_data_l_o           : load result (held)
//   dm_load_done_o, dm_store_done_o : completion pulses
//   dm_ready_o            : data buffer empty and no data access in flight
//   ram_*                 : shared RAM bank interface
//   io_we_o, io_wdata_o, io_rdata_i : I/O word interface
module urv_mem_arbiter
  import urv_mem_arbiter_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          RAM_LATENCY = 1,
  parameter logic [31:0] IO_ADDR     = 32'h1000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              im_req_i,
  input  logic [31:0]       im_addr_i,
  output logic [31:0]       im_data_o,
  output logic              im_valid_o,
  input  logic              dm_load_i,
  input  logic              dm_store_i,
  input  logic [31:0]       dm_addr_i,
  input  logic [31:0]       dm_data_s_i,
  input  logic [3:0]        dm_data_select_i,
  output logic [31:0]       dm_data_l_o,
  output logic              dm_load_done_o,
  output logic              dm_store_done_o,
  output logic              dm_ready_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_di_o,
  output logic [3:0]        ram_we_o,
  output logic              ram_ce_o,
  input  logic [31:0]       ram_do_i,
  output logic              io_we_o,
  output logic [31:0]       io_wdata_o,
  input  logic [31:0]       io_rdata_i
);

  // WAIT lasts RAM_LATENCY cycles; the counter runs 0 .. RAM_LATENCY-1.
  localparam logic [1:0] LAST_CNT = 2'(RAM_LATENCY - 1);

  logic              im_full;
  logic              dm_full;
  logic [31:0]       im_q;
  data_req_t         dm_q;
  data_req_t         dm_new;

  state_e            state_q;
  owner_e            owner_q;
  owner_e            last_grant_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] ram_addr_q;

  logic              im_accept;
  logic              dm_accept;
  logic              grant_any;
  logic              grant_data;
  logic              grant_instr;
  logic              grant_io;
  logic              grant_store;
  logic              grant_read;
  logic              wait_done;
  logic              dm_full_next;
  logic              dm_busy_next;
  logic [31:0]       sel_addr;
  logic              unused_addr_bits;

  // A request is only taken when its port has nothing pending or in flight;
  // anything else is a protocol error and is dropped.
  assign im_accept = im_req_i && !im_full && !(state_q == WAIT && owner_q == INSTR);
  assign dm_accept = (dm_load_i || dm_store_i) && !dm_full &&
                     !(state_q == WAIT && owner_q == DATA);

  assign dm_new = '{addr:  dm_addr_i,
                    wdata: dm_data_s_i,
                    lanes: dm_data_select_i,
                    kind:  dm_store_i ? STORE : LOAD};

  urv_req_buffer #(.WIDTH(32)) u_im_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (im_accept),
    .load_data (im_addr_i),
    .clear     (grant_instr),
    .full      (im_full),
    .data      (im_q)
  );

  urv_req_buffer #(.WIDTH(DATA_REQ_W)) u_dm_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (dm_accept),
    .load_data (dm_new),
    .clear     (grant_data),
    .full      (dm_full),
    .data      (dm_q)
  );

  // Grant decision: when both buffers are pending, the port that did not
  // win last time goes first. Fetches never decode the I/O word.
  always_comb begin
    grant_any   = (state_q == IDLE) && (im_full || dm_full);
    grant_data  = grant_any && dm_full && (!im_full || last_grant_q == INSTR);
    grant_instr = grant_any && !grant_data;
    sel_addr    = grant_data ? dm_q.addr : im_q;
    grant_io    = grant_data && (dm_q.addr == IO_ADDR);
    grant_store = grant_data && (dm_q.kind == STORE);
    grant_read  = grant_any && !grant_io && !grant_store;
    wait_done   = (state_q == WAIT) && (cnt_q == LAST_CNT);
  end

  // Next-cycle view of the data port, registered into dm_ready_o.
  assign dm_full_next = dm_accept || (dm_full && !grant_data);
  assign dm_busy_next = (grant_read && grant_data) ||
                        (state_q == WAIT && owner_q == DATA && !wait_done);

  // Bits outside the word index are deliberately ignored (aliasing).
  assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};

  // The grant cycle drives the RAM straight from the buffer; WAIT and idle
  // cycles replay the registered address.
  assign ram_addr_o = (grant_any && !grant_io) ? sel_addr[ADDR_W+1:2] : ram_addr_q;
  assign ram_ce_o   = (grant_any && !grant_io) || (state_q == WAIT);
  assign ram_we_o   = (grant_store && !grant_io) ? dm_q.lanes : 4'b0000;
  assign ram_di_o   = dm_q.wdata;
  assign io_we_o    = grant_store && grant_io;
  assign io_wdata_o = dm_q.wdata;

  // Stores and I/O finish in the grant cycle and stay in IDLE; RAM reads
  // park in WAIT until ram_do_i is valid, then capture and pulse done.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q         <= IDLE;
      owner_q         <= INSTR;
      last_grant_q    <= INSTR;
      cnt_q           <= 2'd0;
      ram_addr_q      <= '0;
      im_data_o       <= 32'd0;
      im_valid_o      <= 1'b0;
      dm_data_l_o     <= 32'd0;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      dm_ready_o      <= 1'b1;
    end else begin
      im_valid_o      <= 1'b0;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      dm_ready_o      <= !dm_full_next && !dm_busy_next;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            last_grant_q <= grant_data ? DATA : INSTR;
            if (!grant_io) begin
              ram_addr_q <= sel_addr[ADDR_W+1:2];
            end
            if (grant_store) begin
              dm_store_done_o <= 1'b1;
            end else if (grant_io) begin
              dm_load_done_o <= 1'b1;
              dm_data_l_o    <= io_rdata_i;
            end else begin
              state_q <= WAIT;
              owner_q <= grant_data ? DATA : INSTR;
              cnt_q   <= 2'd0;
            end
          end
        end
        WAIT: begin
          if (cnt_q == LAST_CNT) begin
            state_q <= IDLE;
            if (owner_q == DATA) begin
              dm_data_l_o    <= ram_do_i;
              dm_load_done_o <= 1'b1;
            end else begin
              im_data_o  <= ram_do_i;
              im_valid_o <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_urv_mem_arbiter.sv
// tb_urv_mem_arbiter
// Directed scenarios plus randomized traffic against a transaction-level
// model of the arbiter. A second instance with RAM_LATENCY=2 shares the
// stimulus for the latency-2 timing scenario.
module tb_urv_mem_arbiter;
  localparam int          L1 = 1;
  localparam logic [31:0] IO = 32'h1000_0000;

  logic clk;
  logic rst;
  logic im_req;
  logic [31:0] im_addr;
  logic dm_load;
  logic dm_store;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0] dm_sel;
  logic [31:0] io_rdata;

  logic [31:0] im_data, dm_data_l, ram_di, ram_do, io_wdata;
  logic im_valid, dm_load_done, dm_store_done, dm_ready, ram_ce, io_we;
  logic [9:0] ram_addr;
  logic [3:0] ram_we;

  logic [31:0] im_data2, dm_data_l2, ram_di2, ram_do2, io_wdata2;
  logic im_valid2, dm_load_done2, dm_store_done2, dm_ready2, ram_ce2, io_we2;
  logic [9:0] ram_addr2;
  logic [3:0] ram_we2;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int req_cyc = 0;
  int im_cyc, ld_cyc, st_cyc;
  logic [31:0] im_got, ld_got, io_got;
  logic [31:0] model_mem [0:1023];

  urv_mem_arbiter #(.ADDR_W(10), .RAM_LATENCY(1), .IO_ADDR(IO)) dut (
    .clk_i(clk), .rst_i(rst),
    .im_req_i(im_req), .im_addr_i(im_addr), .im_data_o(im_data), .im_valid_o(im_valid),
    .dm_load_i(dm_load), .dm_store_i(dm_store), .dm_addr_i(dm_addr),
    .dm_data_s_i(dm_wdata), .dm_data_select_i(dm_sel), .dm_data_l_o(dm_data_l),
    .dm_load_done_o(dm_load_done), .dm_store_done_o(dm_store_done), .dm_ready_o(dm_ready),
    .ram_addr_o(ram_addr), .ram_di_o(ram_di), .ram_we_o(ram_we), .ram_ce_o(ram_ce),
    .ram_do_i(ram_do), .io_we_o(io_we), .io_wdata_o(io_wdata), .io_rdata_i(io_rdata)
  );

  urv_mem_arbiter #(.ADDR_W(10), .RAM_LATENCY(2), .IO_ADDR(IO)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .im_req_i(im_req), .im_addr_i(im_addr), .im_data_o(im_data2), .im_valid_o(im_valid2),
    .dm_load_i(dm_load), .dm_store_i(dm_store), .dm_addr_i(dm_addr),
    .dm_data_s_i(dm_wdata), .dm_data_select_i(dm_sel), .dm_data_l_o(dm_data_l2),
    .dm_load_done_o(dm_load_done2), .dm_store_done_o(dm_store_done2), .dm_ready_o(dm_ready2),
    .ram_addr_o(ram_addr2), .ram_di_o(ram_di2), .ram_we_o(ram_we2), .ram_ce_o(ram_ce2),
    .ram_do_i(ram_do2), .io_we_o(io_we2), .io_wdata_o(io_wdata2), .io_rdata_i(io_rdata)
  );

  // Block RAM models: latency 1 for dut, output register added for dut2.
  logic [31:0] mem1 [0:1023];
  logic [31:0] rd1;
  logic [31:0] mem2 [0:1023];
  logic [31:0] rd2a, rd2b;

  always @(posedge clk) begin
    if (ram_ce) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem1[ram_addr][b*8 +: 8] <= ram_di[b*8 +: 8];
      rd1 <= mem1[ram_addr];
    end
  end
  assign ram_do = rd1;

  always @(posedge clk) begin
    if (ram_ce2) begin
      for (int b = 0; b < 4; b++)
        if (ram_we2[b]) mem2[ram_addr2][b*8 +: 8] <= ram_di2[b*8 +: 8];
      rd2a <= mem2[ram_addr2];
    end
    rd2b <= rd2a;
  end
  assign ram_do2 = rd2b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global safety net in case something outside the bounded waits stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one cycle and record any completion pulses seen in it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (im_valid) begin im_cyc = cyc; im_got = im_data; end
    if (dm_load_done) begin ld_cyc = cyc; ld_got = dm_data_l; end
    if (dm_store_done) st_cyc = cyc;
    if (io_we) io_got = io_wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of request pulses; returns in the cycle after them.
  task automatic applyStimulus(input logic f, input logic [31:0] fa, input logic ld,
                               input logic st, input logic [31:0] da,
                               input logic [31:0] wd, input logic [3:0] sel);
    im_cyc = -1; ld_cyc = -1; st_cyc = -1; io_got = 32'd0;
    im_req = f; im_addr = fa; dm_load = ld; dm_store = st;
    dm_addr = da; dm_wdata = wd; dm_sel = sel;
    req_cyc = cyc;
    tick();
    im_req = 1'b0; dm_load = 1'b0; dm_store = 1'b0;
  endtask

  task automatic doOp(input logic f, input logic [31:0] fa, input logic ld, input logic st,
                      input logic [31:0] da, input logic [31:0] wd, input logic [3:0] sel);
    applyStimulus(f, fa, ld, st, da, wd, sel);
    for (int k = 0; k < 20; k++) begin
      if ((!f || im_cyc >= 0) && (!(ld || st) || (st ? st_cyc >= 0 : ld_cyc >= 0))) break;
      tick();
    end
    repeat (3) tick();
  endtask

  function automatic logic [31:0] randAddr(input int w);
    logic [31:0] a;
    a = ($urandom & 32'hFFFF_F000) | (32'(w) << 2) | 32'($urandom_range(0, 3));
    if (a == IO) a = a ^ 32'h0000_4000;
    return a;
  endfunction

  initial begin
    logic lg_data;
    int fk, dk, w, wf;
    logic [31:0] fa, da, wd, iov, exp_f, exp_l, exp_io;
    logic [3:0] sel;
    int t, dur_d, exp_fc, exp_dc;
    logic data_first;

    rst = 1'b0; im_req = 0; im_addr = 0; dm_load = 0; dm_store = 0;
    dm_addr = 0; dm_wdata = 0; dm_sel = 0; io_rdata = 0;
    im_cyc = -1; ld_cyc = -1; st_cyc = -1; im_got = 0; ld_got = 0; io_got = 0;
    tick(); tick();
    rst = 1'b1;

    // Reset state
    checkOutput("rst_im_valid", im_valid, 0);
    checkOutput("rst_ld_done", dm_load_done, 0);
    checkOutput("rst_st_done", dm_store_done, 0);
    checkOutput("rst_ram_ce", ram_ce, 0);
    checkOutput("rst_ram_we", ram_we, 0);
    checkOutput("rst_io_we", io_we, 0);
    checkOutput("rst_im_data", im_data, 0);
    checkOutput("rst_dm_data", dm_data_l, 0);
    checkOutput("rst_ready", dm_ready, 1);

    // Preload words 0x10 and 0x11 through full-word stores
    applyStimulus(0, 0, 0, 1, 32'h40, 32'hDEAD_BEEF, 4'hF);
    checkOutput("pre_we", ram_we, 4'hF);
    checkOutput("pre_ce", ram_ce, 1);
    checkOutput("pre_di", ram_di, 32'hDEAD_BEEF);
    tick();
    checkOutput("pre_done", dm_store_done, 1);
    repeat (3) tick();
    doOp(0, 0, 0, 1, 32'h44, 32'h1122_3344, 4'hF);

    // Fetch, L=1
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
    checkOutput("fetch_addr", ram_addr, 10'h10);
    checkOutput("fetch_ce", ram_ce, 1);
    checkOutput("fetch_we", ram_we, 0);
    tick();
    checkOutput("fetch_wait_ce", ram_ce, 1);
    checkOutput("fetch_early", im_valid, 0);
    tick();
    checkOutput("fetch_valid", im_valid, 1);
    checkOutput("fetch_data", im_data, 32'hDEAD_BEEF);
    tick();
    checkOutput("idle_ce", ram_ce, 0);
    checkOutput("idle_addr", ram_addr, 10'h10);
    repeat (2) tick();

    // Byte store, then load of the merged word
    applyStimulus(0, 0, 0, 1, 32'h44, 32'h0000_00AA, 4'b0001);
    checkOutput("bst_we", ram_we, 4'b0001);
    checkOutput("bst_addr", ram_addr, 10'h11);
    tick();
    checkOutput("bst_done", dm_store_done, 1);
    repeat (3) tick();
    applyStimulus(0, 0, 1, 0, 32'h44, 0, 0);
    checkOutput("ld_ready_low", dm_ready, 0);
    tick(); tick();
    checkOutput("ld_done", dm_load_done, 1);
    checkOutput("ld_data", dm_data_l, 32'h1122_33AA);
    checkOutput("ld_ready_back", dm_ready, 1);
    repeat (3) tick();

    // I/O store and load
    applyStimulus(0, 0, 0, 1, IO, 32'h0000_005A, 4'hF);
    checkOutput("io_we", io_we, 1);
    checkOutput("io_wdata", io_wdata, 32'h5A);
    checkOutput("io_ram_ce", ram_ce, 0);
    tick();
    checkOutput("io_st_done", dm_store_done, 1);
    repeat (3) tick();
    io_rdata = 32'h77;
    applyStimulus(0, 0, 1, 0, IO, 0, 0);
    checkOutput("io_ld_ce", ram_ce, 0);
    tick();
    checkOutput("io_ld_done", dm_load_done, 1);
    checkOutput("io_ld_data", dm_data_l, 32'h77);
    repeat (3) tick();

    // Latency 2 fetch on the second instance
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      checkOutput("l2_ce", ram_ce2, 1);
      checkOutput("l2_addr", ram_addr2, 10'h10);
      checkOutput("l2_early", im_valid2, 0);
      tick();
    end
    checkOutput("l2_valid", im_valid2, 1);
    checkOutput("l2_data", im_data2, 32'hDEAD_BEEF);
    repeat (4) tick();

    // Reset while a load is waiting on the RAM
    applyStimulus(0, 0, 1, 0, 32'h44, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("rmid_no_done", dm_load_done, 0);
    checkOutput("rmid_ready", dm_ready, 1);
    repeat (4) tick();
    checkOutput("rmid_no_late_done", 32'(ld_cyc), 32'hFFFF_FFFF);

    // Contention after reset: data first, then instruction
    applyStimulus(1, 32'h40, 1, 0, 32'h44, 0, 0);
    checkOutput("cont1_data_first", ram_addr, 10'h11);
    tick(); tick();
    checkOutput("cont1_instr_addr", ram_addr, 10'h10);
    checkOutput("cont1_instr_ce", ram_ce, 1);
    repeat (5) tick();
    checkOutput("cont1_ld_cyc", 32'(ld_cyc - req_cyc), 3);
    checkOutput("cont1_im_cyc", 32'(im_cyc - req_cyc), 5);
    checkOutput("cont1_ld_data", ld_got, 32'h1122_33AA);
    checkOutput("cont1_im_data", im_got, 32'hDEAD_BEEF);
    applyStimulus(1, 32'h44, 1, 0, 32'h40, 0, 0);
    checkOutput("cont2_data_first", ram_addr, 10'h10);
    repeat (7) tick();
    checkOutput("cont2_ld_cyc", 32'(ld_cyc - req_cyc), 3);
    checkOutput("cont2_im_cyc", 32'(im_cyc - req_cyc), 5);
    checkOutput("cont2_ld_data", ld_got, 32'hDEAD_BEEF);
    checkOutput("cont2_im_data", im_got, 32'h1122_33AA);

    // Randomized traffic against the transaction model
    rst = 1'b0; tick(); rst = 1'b1; tick();
    lg_data = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      model_mem[i] = wd;
      doOp(0, 0, 0, 1, randAddr(i), wd, 4'hF);
      checkOutput("rinit_st_cyc", 32'(st_cyc - req_cyc), 2);
      lg_data = 1'b1;
    end

    for (int i = 0; i < 40; i++) begin
      fk = $urandom_range(0, 6);
      // f: 1 normal fetch, 2 fetch of IO_ADDR; dk: 0 none,1 load,2 store,3 io load,4 io store
      case (fk)
        0: begin wf = 1; dk = 0; end
        1: begin wf = 0; dk = 1; end
        2: begin wf = 0; dk = 2; end
        3: begin wf = 0; dk = 3; end
        4: begin wf = 0; dk = 4; end
        5: begin wf = 2; dk = 0; end
        default: begin wf = 1; dk = $urandom_range(1, 4); end
      endcase
      w = $urandom_range(0, 15);
      fa = (wf == 2) ? IO : randAddr($urandom_range(0, 15));
      da = (dk >= 3) ? IO : randAddr(w);
      wd = $urandom;
      sel = 4'($urandom_range(1, 15));
      iov = $urandom;
      io_rdata = iov;

      data_first = (dk != 0) && (wf == 0 || !lg_data);
      dur_d = (dk == 1) ? L1 + 1 : 1;
      exp_f = 0; exp_l = 0; exp_io = 0; exp_fc = 0; exp_dc = 0;
      t = 1;
      for (int s = 0; s < 2; s++) begin
        if ((s == 0) == data_first && dk != 0) begin
          exp_dc = t + dur_d;
          t = t + dur_d;
          if (dk == 1) exp_l = model_mem[da[11:2]];
          if (dk == 3) exp_l = iov;
          if (dk == 4) exp_io = wd;
          if (dk == 2)
            for (int b = 0; b < 4; b++)
              if (sel[b]) model_mem[da[11:2]][b*8 +: 8] = wd[b*8 +: 8];
          lg_data = 1'b1;
        end else if ((s == 0) != data_first && wf != 0) begin
          exp_fc = t + L1 + 1;
          t = t + L1 + 1;
          exp_f = model_mem[fa[11:2]];
          lg_data = 1'b0;
        end
      end

      doOp(wf != 0, fa, dk == 1 || dk == 3, dk == 2 || dk == 4, da, wd, sel);

      if (wf != 0) begin
        checkOutput("rnd_f_cyc", 32'(im_cyc - req_cyc), 32'(exp_fc));
        checkOutput("rnd_f_data", im_got, exp_f);
      end
      if (dk == 1 || dk == 3) begin
        checkOutput("rnd_l_cyc", 32'(ld_cyc - req_cyc), 32'(exp_dc));
        checkOutput("rnd_l_data", ld_got, exp_l);
      end
      if (dk == 2 || dk == 4) begin
        checkOutput("rnd_s_cyc", 32'(st_cyc - req_cyc), 32'(exp_dc));
      end
      if (dk == 4) begin
        checkOutput("rnd_io_wdata", io_got, exp_io);
      end
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
